gmii_tx_framer: RTL
===================

# gmii_tx_framer

Transmit-side Ethernet framer that turns a payload byte stream plus header fields into a complete GMII transmit sequence: preamble, SFD, destination/source MAC, ethertype, payload, zero padding to the 60-byte minimum, CRC-32 FCS and inter-frame gap. It sits between the ethernet switch's transmit path and the GMII PHY interface, clocked by the GMII tx clock. It is the counterpart of the existing GMII receive deframer.

## Interface
- IFG, 12, idle cycles (tx_en low) enforced after each frame's last FCS byte
- MINPAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded
- MTU, 1500, maximum payload bytes; longer payloads are truncated
- clk  in  1  GMII tx clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- dmac  in  48  destination MAC, sampled on frame accept
- smac  in  48  source MAC, sampled on frame accept
- ethertype  in  16  sampled on frame accept
- dven  in  1  payload byte valid
- data  in  8  payload byte
- last  in  1  qualifies final payload byte (with dven)
- dready  out  1  payload byte consumed when dven&dready
- busy  out  1  high from accept until end of IFG
- txd  out  8  GMII transmit data, registered
- tx_en  out  1  GMII transmit enable, registered
- tx_er  out  1  GMII transmit error, registered
- oversize  out  1  one-cycle pulse when a frame is truncated at MTU
- framecnt  out  16  completed frames, wraps 0xffff->0

## Operation
- States: IDLE, PRE, SFD, HDR, PAY, PAD, FCS, ERR, GAP.
- IDLE: dven high -> latch dmac/smac/ethertype, enter PRE, busy=1. dready low outside PAY.
- PRE: 7 bytes 0x55. SFD: 1 byte 0xd5.
- HDR: 14 bytes, dmac MSB first, smac MSB first, ethertype MSB first.
- PAY: dready=1 combinationally; each accepted byte sent next cycle. Payload counter (11 bits) increments per byte.
  - last accepted: count<MINPAYLOAD -> PAD, else FCS.
  - count reaches MTU without last: byte MTU treated as last, oversize pulses, remaining source bytes are not accepted (source owns the flush).
  - dven low in PAY (underrun): -> ERR.
- PAD: 0x00 bytes until payload+pad = MINPAYLOAD, then FCS.
- FCS: CRC-32, reflected poly 0xEDB88320, init 0xffffffff, over header+payload+pad; send ~crc, least-significant byte first, 4 bytes. Then GAP, framecnt+1.
- ERR: one cycle tx_en=1, tx_er=1, txd=0x00; then GAP; framecnt unchanged.
- GAP: IFG cycles tx_en=0, then IDLE. dven ignored until IDLE.
- tx_er=0 in all states except ERR.

## Timing
- Reset values: txd=0x00, tx_en=0, tx_er=0, dready=0, busy=0, oversize=0, framecnt=0; state IDLE, CRC=0xffffffff.
- Reset mid-frame: next cycle tx_en=0, state IDLE; no FCS, no GAP, framecnt cleared.
- Accept at cycle 0 -> tx_en=1, txd=0x55 at cycle 1; SFD cycle 8; header cycles 9-22; first payload byte cycle 23 (dready high cycles 22 onward; byte accepted cycle k appears at k+1).
- Frame with P payload bytes: tx_en high for 8+14+max(P,MINPAYLOAD)+4 contiguous cycles (ERR: up to and including ERR byte).
- Minimum frame spacing: last FCS byte to next 0x55 is IFG+1 cycles (GAP plus IDLE accept cycle).
- oversize pulses the cycle the MTU-th byte is accepted.

## Test plan
- ARP: dmac ffffffffffff, smac c46e1f01d90d, ethertype 0806, 28-byte ARP request (0001 0800 0604 0001 c46e1f01d90d c0a801c8 000000000000 c0a801e0) -> 72 tx_en cycles, 18 zero pad bytes, FCS bytes 72 bd a5 6a, framecnt=1.
- ICMP echo: dmac 00105ad155b2, smac c46e1f01d90d, ethertype 0800, 84-byte IPv4/ICMP payload from 4500 0054 a662 ... 3637 -> 110 tx_en cycles, no pad, FCS 0c b5 55 72.
- Back-to-back: second frame's dven held high during GAP -> exactly 12 tx_en-low cycles plus one accept cycle between frames; both FCS correct.
- Underrun: drop dven for one cycle at payload byte 10 -> one byte with tx_en=1, tx_er=1, txd=00, then GAP; framecnt unchanged.
- Oversize: MTU=64 build, 100-byte stream -> 64 payload bytes sent, oversize pulse on byte 64, valid FCS over truncated frame.
- Reset at header byte 5 -> tx_en=0 next cycle, busy=0, framecnt=0; subsequent ARP frame matches scenario 1.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: builds a complete GMII transmit frame (preamble, SFD,
// MAC header, payload, zero pad, CRC-32 FCS) from a payload byte stream,
// then holds off the next frame for the inter-frame gap.
module gmii_tx_framer #(
  parameter int unsigned IFG        = 12,
  parameter int unsigned MINPAYLOAD = 46,
  parameter int unsigned MTU        = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] dmac,
  input  logic [47:0] smac,
  input  logic [15:0] ethertype,
  input  logic        dven,
  input  logic [7:0]  data,
  input  logic        last,
  output logic        dready,
  output logic        busy,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_er,
  output logic        oversize,
  output logic [15:0] framecnt
);

  typedef enum logic [3:0] {
    IDLE, PRE, SFD, HDR, PAY, PAD, FCS, ERR, GAP
  } state_t;

  localparam logic [10:0] MIN_L     = 11'(MINPAYLOAD);
  localparam logic [10:0] MTU_LAST  = 11'(MTU - 1);
  localparam logic [10:0] MIN_LAST  = 11'(MINPAYLOAD - 1);
  localparam logic [10:0] GAP_LAST  = 11'(IFG - 1);

  state_t       state_q, state_d;
  logic [10:0]  cnt_q, cnt_d;
  logic [111:0] hdr_q, hdr_d;
  logic [31:0]  crc_q, crc_d;
  logic [15:0]  framecnt_q, framecnt_d;
  logic [7:0]   txd_q, txd_d;
  logic         tx_en_q, tx_en_d;
  logic         tx_er_q, tx_er_d;
  logic [31:0]  crc_inv;

  // Byte-wise update of the reflected CRC-32 (poly 0xEDB88320).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_inv  = ~crc_q;
  assign busy     = (state_q != IDLE);
  assign txd      = txd_q;
  assign tx_en    = tx_en_q;
  assign tx_er    = tx_er_q;
  assign framecnt = framecnt_q;

  // State register and registered GMII outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      crc_q      <= '1;
      framecnt_q <= '0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      crc_q      <= crc_d;
      framecnt_q <= framecnt_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
    end
  end

  // Next-state logic; each state computes the byte that appears on the wire
  // one cycle later, so the accept cycle already launches the first 0x55.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    crc_d      = crc_q;
    framecnt_d = framecnt_q;
    txd_d      = '0;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    dready     = 1'b0;
    oversize   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dven) begin
          state_d = PRE;
          cnt_d   = '0;
          hdr_d   = {dmac, smac, ethertype};
          crc_d   = '1;
          txd_d   = 8'h55;
          tx_en_d = 1'b1;
        end
      end
      PRE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
        if (cnt_q == 11'd5) begin
          state_d = SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      SFD: begin
        txd_d   = 8'hd5;
        tx_en_d = 1'b1;
        state_d = HDR;
        cnt_d   = '0;
      end
      HDR: begin
        txd_d   = hdr_q[111:104];
        tx_en_d = 1'b1;
        hdr_d   = {hdr_q[103:0], 8'h00};
        crc_d   = crc_byte(crc_q, hdr_q[111:104]);
        if (cnt_q == 11'd13) begin
          state_d = PAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      PAY: begin
        dready = 1'b1;
        if (dven) begin
          txd_d   = data;
          tx_en_d = 1'b1;
          crc_d   = crc_byte(crc_q, data);
          cnt_d   = cnt_q + 11'd1;
          if (last || (cnt_q == MTU_LAST)) begin
            oversize = !last;
            if ((cnt_q + 11'd1) < MIN_L) begin
              state_d = PAD;
            end else begin
              state_d = FCS;
              cnt_d   = '0;
            end
          end
        end else begin
          // Underrun: the error byte is launched now, ERR is its wire cycle.
          txd_d   = 8'h00;
          tx_en_d = 1'b1;
          tx_er_d = 1'b1;
          state_d = ERR;
        end
      end
      PAD: begin
        txd_d   = 8'h00;
        tx_en_d = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        if (cnt_q == MIN_LAST) begin
          state_d = FCS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      FCS: begin
        txd_d   = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
        tx_en_d = 1'b1;
        if (cnt_q == 11'd3) begin
          state_d    = GAP;
          cnt_d      = '0;
          framecnt_d = framecnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ERR: begin
        // The error byte's wire cycle doubles as the first gap count.
        state_d = GAP;
        cnt_d   = 11'd1;
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
